// File: rtl/binary_quiz_engine.sv
// Binary quiz engine: shows a decimal target digit, the player builds the
// matching 4-bit binary answer with toggle buttons, submits it, and sees a
// correct/wrong code followed by a fresh pseudo-random target. A running
// streak of consecutive correct answers can be displayed on request.
module binary_quiz_engine #(
  parameter int unsigned HOLD_CYCLES = 10_000_000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  input  logic       btn5,
  input  logic       btn6,
  input  logic       btn7,
  output logic [3:0] value,
  output logic [3:0] entry,
  output logic [3:0] score,
  output logic       busy
);

  // Hold counter needs to reach HOLD_CYCLES-1; one spare bit keeps the
  // width sane for tiny HOLD_CYCLES values such as 1.
  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  // Display codes understood by the 7-segment driver beyond plain digits.
  localparam logic [3:0] CODE_RIGHT = 4'd10;
  localparam logic [3:0] CODE_WRONG = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd12;

  typedef enum logic [1:0] {
    ASK    = 2'd0,
    RESULT = 2'd1,
    SCORE  = 2'd2,
    NEXT   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [7:0]        lfsr;
  logic [7:0]        lfsr_n;
  logic [3:0]        target;
  logic [3:0]        target_n;
  logic [3:0]        value_n;
  logic [3:0]        entry_n;
  logic [3:0]        score_n;
  logic              busy_n;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_n;
  logic [3:0]        candidate;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Streak counter saturates at the largest displayable digit.
  function automatic logic [3:0] sat_inc_score(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  // Fold a raw nibble into 0-9 with a single conditional subtract.
  function automatic logic [3:0] fold_digit(input logic [3:0] r);
    return (r < 4'd10) ? r : r - 4'd10;
  endfunction

  // Bump the candidate by one (mod 10) so a round never repeats its target.
  function automatic logic [3:0] pick_target(input logic [3:0] cand,
                                             input logic [3:0] old);
    logic [3:0] bumped;
    bumped = (cand == 4'd9) ? 4'd0 : cand + 4'd1;
    return (cand == old) ? bumped : cand;
  endfunction

  assign candidate = fold_digit(lfsr[3:0]);

  // State and all registered outputs; reset forces a clean ASK with target 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ASK;
      lfsr   <= LFSR_SEED;
      target <= 4'd0;
      value  <= 4'd0;
      entry  <= 4'd0;
      score  <= 4'd0;
      busy   <= 1'b0;
      hold   <= '0;
    end else begin
      state  <= state_n;
      lfsr   <= lfsr_n;
      target <= target_n;
      value  <= value_n;
      entry  <= entry_n;
      score  <= score_n;
      busy   <= busy_n;
      hold   <= hold_n;
    end
  end

  // Next-state and next-output decode; ASK resolves one button action per cycle.
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr_step(lfsr);
    target_n = target;
    value_n  = value;
    entry_n  = entry;
    score_n  = score;
    busy_n   = busy;
    hold_n   = hold;

    case (state)
      ASK: begin
        value_n = target;
        busy_n  = 1'b0;
        if (btn5) begin
          if (entry == target) begin
            score_n = sat_inc_score(score);
            value_n = CODE_RIGHT;
          end else begin
            score_n = 4'd0;
            value_n = CODE_WRONG;
          end
          hold_n  = '0;
          busy_n  = 1'b1;
          state_n = RESULT;
        end else if (btn6) begin
          entry_n = 4'd0;
        end else if (btn7) begin
          value_n = score;
          hold_n  = '0;
          busy_n  = 1'b1;
          state_n = SCORE;
        end else begin
          entry_n = entry ^ {btn1, btn2, btn3, btn4};
        end
      end

      RESULT, SCORE: begin
        // Buttons are deliberately ignored while the display is held.
        if (hold == HOLD_LAST) begin
          hold_n = '0;
          busy_n = 1'b0;
          if (state == RESULT) begin
            value_n = CODE_BLANK;
            state_n = NEXT;
          end else begin
            value_n = target;
            state_n = ASK;
          end
        end else begin
          hold_n = hold + HOLD_W'(1);
          busy_n = 1'b1;
        end
      end

      NEXT: begin
        target_n = pick_target(candidate, target);
        value_n  = target_n;
        entry_n  = 4'd0;
        busy_n   = 1'b0;
        hold_n   = '0;
        state_n  = ASK;
      end

      default: begin
        state_n = ASK;
        busy_n  = 1'b0;
        hold_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_binary_quiz_engine.sv
// Directed bench for binary_quiz_engine with a short hold time. A small
// reference LFSR and score/target bookkeeping supply the expected values.
module tb_binary_quiz_engine;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0, btn4 = 1'b0;
  logic       btn5 = 1'b0, btn6 = 1'b0, btn7 = 1'b0;
  logic [3:0] value, entry, score;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_lfsr;
  logic [3:0] cur_target;
  logic [3:0] exp_entry;
  logic [3:0] exp_score;

  binary_quiz_engine #(.HOLD_CYCLES(HOLD), .LFSR_SEED(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .btn1  (btn1),
    .btn2  (btn2),
    .btn3  (btn3),
    .btn4  (btn4),
    .btn5  (btn5),
    .btn6  (btn6),
    .btn7  (btn7),
    .value (value),
    .entry (entry),
    .score (score),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, advanced on every clock out of reset.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b[0]=btn1 ... b[6]=btn7, held for exactly one clock edge.
  task automatic press(input logic [6:0] b);
    {btn7, btn6, btn5, btn4, btn3, btn2, btn1} = b;
    tick();
    {btn7, btn6, btn5, btn4, btn3, btn2, btn1} = 7'b0;
  endtask

  task automatic do_reset(input string tg);
    reset = 1'b1;
    #2;
    check_eq({tg, "_rst_value"}, value, 0);
    check_eq({tg, "_rst_entry"}, entry, 0);
    check_eq({tg, "_rst_score"}, score, 0);
    check_eq({tg, "_rst_busy"},  busy,  0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    cur_target = 4'd0;
    exp_entry  = 4'd0;
    exp_score  = 4'd0;
    check_eq({tg, "_rel_value"}, value, 0);
    check_eq({tg, "_rel_busy"},  busy,  0);
  endtask

  // Set entry to ans with one multi-toggle, submit, ride through RESULT and
  // NEXT, and confirm the new target drawn from the reference LFSR.
  task automatic do_round(input logic [3:0] ans, input string tg);
    logic [3:0] m;
    logic [3:0] cand;
    logic [3:0] nt;
    bit         ok;
    m = exp_entry ^ ans;
    press({3'b000, m[0], m[1], m[2], m[3]});
    exp_entry = ans;
    check_eq({tg, "_entry"}, entry, exp_entry);
    check_eq({tg, "_ask_value"}, value, cur_target);
    check_eq({tg, "_ask_busy"}, busy, 0);
    ok = (ans == cur_target);
    exp_score = ok ? ((exp_score == 4'd9) ? 4'd9 : exp_score + 4'd1) : 4'd0;
    press(7'b0010000);
    check_eq({tg, "_result_value"}, value, ok ? 10 : 11);
    check_eq({tg, "_result_busy"}, busy, 1);
    check_eq({tg, "_score"}, score, exp_score);
    check_eq({tg, "_result_entry"}, entry, exp_entry);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check_eq({tg, "_hold_busy"}, busy, 1);
      check_eq({tg, "_hold_value"}, value, ok ? 10 : 11);
    end
    tick();
    check_eq({tg, "_next_value"}, value, 12);
    check_eq({tg, "_next_busy"}, busy, 0);
    cand = (m_lfsr[3:0] < 4'd10) ? m_lfsr[3:0] : m_lfsr[3:0] - 4'd10;
    if (cand == cur_target) nt = (cand == 4'd9) ? 4'd0 : cand + 4'd1;
    else                    nt = cand;
    tick();
    check_eq({tg, "_new_target"}, value, nt);
    check_eq({tg, "_new_target_differs"}, int'(value != cur_target), 1);
    check_eq({tg, "_new_entry"}, entry, 0);
    check_eq({tg, "_new_busy"}, busy, 0);
    cur_target = nt;
    exp_entry  = 4'd0;
  endtask

  initial begin
    logic [3:0] ans;
    cur_target = 4'd0;
    exp_entry  = 4'd0;
    exp_score  = 4'd0;
    #3;

    // Reset state, then a correct first answer (entry 0 vs target 0).
    do_reset("r0");
    do_round(4'd0, "first");

    // Wrong answer 0011 against target 0.
    do_reset("r1");
    press(7'b0000100);
    check_eq("btn3_entry", entry, 4'b0010);
    press(7'b0001000);
    check_eq("btn4_entry", entry, 4'b0011);
    exp_entry = 4'b0011;
    do_round(4'b0011, "wrong");

    // Simultaneous toggles, then clear beating a toggle and a score request.
    press(7'b0000011);
    check_eq("dual_toggle", entry, 4'b1100);
    press(7'b0100001);
    check_eq("clear_wins_toggle", entry, 0);
    press(7'b0000101);
    check_eq("toggle_1010", entry, 4'b1010);
    press(7'b1100000);
    check_eq("clear_wins_score_entry", entry, 0);
    check_eq("clear_wins_score_busy", busy, 0);
    exp_entry = 4'd0;

    // Ten correct rounds saturate the streak at 9, then show the score.
    for (int r = 0; r < 10; r++) do_round(cur_target, "streak");
    check_eq("score_saturated", score, 9);
    press(7'b1000010);
    check_eq("score_show_value", value, 9);
    check_eq("score_show_busy", busy, 1);
    check_eq("score_show_entry", entry, 0);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check_eq("score_hold_value", value, 9);
      check_eq("score_hold_busy", busy, 1);
    end
    tick();
    check_eq("score_back_value", value, cur_target);
    check_eq("score_back_busy", busy, 0);

    // Buttons ignored during RESULT, then reset aborts the hold.
    press(7'b0000001);
    exp_entry = 4'b1000;
    check_eq("pre_entry", entry, 4'b1000);
    press(7'b0010000);
    check_eq("ign_result_busy", busy, 1);
    press(7'b0000001);
    check_eq("ign_btn1_entry", entry, 4'b1000);
    press(7'b0010000);
    check_eq("ign_btn5_busy", busy, 1);
    do_reset("abort");
    tick();
    check_eq("abort_value", value, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_score", score, 0);

    // Long run with a mix of correct and random answers.
    for (int r = 0; r < 1000; r++) begin
      if ($urandom_range(0, 1) == 1) ans = cur_target;
      else                           ans = 4'($urandom_range(0, 15));
      do_round(ans, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
